// File: rtl/four_bit_wallace_if.sv
// Operand/product bundle for the 4x4 Wallace multiplier.
// The master drives the operands and the slave returns the product.
interface four_bit_wallace_if;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;

    logic [OP_W-1:0]   A;
    logic [OP_W-1:0]   B;
    logic              in_valid;
    logic [PROD_W-1:0] prod;
    logic              out_valid;

    modport master (
        output A,
        output B,
        output in_valid,
        input  prod,
        input  out_valid
    );

    modport slave (
        input  A,
        input  B,
        input  in_valid,
        output prod,
        output out_valid
    );
endinterface

// File: rtl/four_bit_wallace.sv
// Unsigned 4x4 multiplier: AND-gate partial products, a two-stage Wallace reduction and a ripple adder.
// Define WALLACE_PIPE_EN to register prod/out_valid on clk. Without it the outputs are combinational.
module four_bit_wallace (
    input  logic              clk,
    input  logic              reset,
    four_bit_wallace_if.slave bus
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;

    // Partial products: w_pp[i][j] = A[j] & B[i], weight 2^(i+j)
    logic [OP_W-1:0] w_pp [OP_W];

    for (genvar i = 0; i < OP_W; i++) begin : g_pp
        assign w_pp[i] = bus.A & {OP_W{bus.B[i]}};
    end

    // Stage 1 column heights 1,2,3,4,3,2,1 -> 1,1,2,3,2,2,2
    logic w_h1_s, w_h1_c;
    logic w_f1_s, w_f1_c;
    logic w_f2_s, w_f2_c;
    logic w_f3_s, w_f3_c;
    logic w_h2_s, w_h2_c;

    four_bit_wallace_ha u_h1 (.i_a(w_pp[0][1]), .i_b(w_pp[1][0]),
                              .o_s(w_h1_s), .o_c(w_h1_c));
    four_bit_wallace_fa u_f1 (.i_a(w_pp[0][2]), .i_b(w_pp[1][1]), .i_c(w_pp[2][0]),
                              .o_s(w_f1_s), .o_c(w_f1_c));
    four_bit_wallace_fa u_f2 (.i_a(w_pp[0][3]), .i_b(w_pp[1][2]), .i_c(w_pp[2][1]),
                              .o_s(w_f2_s), .o_c(w_f2_c));
    four_bit_wallace_fa u_f3 (.i_a(w_pp[1][3]), .i_b(w_pp[2][2]), .i_c(w_pp[3][1]),
                              .o_s(w_f3_s), .o_c(w_f3_c));
    four_bit_wallace_ha u_h2 (.i_a(w_pp[2][3]), .i_b(w_pp[3][2]),
                              .o_s(w_h2_s), .o_c(w_h2_c));

    // Stage 2: only column 3 still holds three bits; pairs elsewhere go through half adders
    logic w_h3_s, w_h3_c;
    logic w_f4_s, w_f4_c;
    logic w_h4_s, w_h4_c;
    logic w_h5_s, w_h5_c;
    logic w_h6_s, w_h6_c;

    four_bit_wallace_ha u_h3 (.i_a(w_f1_s), .i_b(w_h1_c),
                              .o_s(w_h3_s), .o_c(w_h3_c));
    four_bit_wallace_fa u_f4 (.i_a(w_f2_s), .i_b(w_pp[3][0]), .i_c(w_f1_c),
                              .o_s(w_f4_s), .o_c(w_f4_c));
    four_bit_wallace_ha u_h4 (.i_a(w_f3_s), .i_b(w_f2_c),
                              .o_s(w_h4_s), .o_c(w_h4_c));
    four_bit_wallace_ha u_h5 (.i_a(w_h2_s), .i_b(w_f3_c),
                              .o_s(w_h5_s), .o_c(w_h5_c));
    four_bit_wallace_ha u_h6 (.i_a(w_pp[3][3]), .i_b(w_h2_c),
                              .o_s(w_h6_s), .o_c(w_h6_c));

    // Final ripple adder over columns 3..7; columns 0..2 are already single bits
    logic w_c3, w_c4, w_c5, w_c6;
    logic w_p3, w_p4, w_p5, w_p6, w_p7;
    logic w_c7_unused;

    four_bit_wallace_ha u_r3 (.i_a(w_f4_s), .i_b(w_h3_c),
                              .o_s(w_p3), .o_c(w_c3));
    four_bit_wallace_fa u_r4 (.i_a(w_h4_s), .i_b(w_f4_c), .i_c(w_c3),
                              .o_s(w_p4), .o_c(w_c4));
    four_bit_wallace_fa u_r5 (.i_a(w_h5_s), .i_b(w_h4_c), .i_c(w_c4),
                              .o_s(w_p5), .o_c(w_c5));
    four_bit_wallace_fa u_r6 (.i_a(w_h6_s), .i_b(w_h5_c), .i_c(w_c5),
                              .o_s(w_p6), .o_c(w_c6));
    // 15*15 = 225 < 256, so the column-7 carry is always zero
    four_bit_wallace_ha u_r7 (.i_a(w_h6_c), .i_b(w_c6),
                              .o_s(w_p7), .o_c(w_c7_unused));

    logic [PROD_W-1:0] w_prod;
    assign w_prod = {w_p7, w_p6, w_p5, w_p4, w_p3, w_h3_s, w_h1_s, w_pp[0][0]};

`ifdef WALLACE_PIPE_EN
    logic [PROD_W-1:0] r_prod;
    logic              r_out_valid;

    // One-cycle output register; reset clears it without waiting for clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_prod      <= w_prod;
            r_out_valid <= bus.in_valid;
        end
    end

    assign bus.prod      = r_prod;
    assign bus.out_valid = r_out_valid;
`else
    logic w_unused_clk_rst;

    // clk and reset stay on the port list but play no part in this build
    assign w_unused_clk_rst = clk ^ reset;
    assign bus.prod         = w_prod;
    assign bus.out_valid    = bus.in_valid;
`endif

endmodule

// Half-adder cell
module four_bit_wallace_ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

// Full-adder cell
module four_bit_wallace_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_ab;

    assign w_ab = i_a ^ i_b;
    assign o_s  = w_ab ^ i_c;
    assign o_c  = (i_a & i_b) | (i_c & w_ab);
endmodule

// File: tb/tb_four_bit_wallace.sv
// Self-checking bench for four_bit_wallace; follows the WALLACE_PIPE_EN setting of the build.
// Reference model is plain integer multiplication of the applied operands.
module tb_four_bit_wallace;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    four_bit_wallace_if bus ();

    four_bit_wallace dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_prod(input int a, input int b);
        return 8'(a * b);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input logic v);
        bus.A        = 4'(a);
        bus.B        = 4'(b);
        bus.in_valid = v;
    endtask

`ifdef WALLACE_PIPE_EN
    // Apply operands mid-cycle, then check the registered result just after the next edge
    task automatic step(input string tag, input int a, input int b, input logic v);
        @(negedge clk);
        drive(a, b, v);
        @(posedge clk);
        #1;
        check({tag, "_prod"}, bus.prod, model_prod(a, b));
        check({tag, "_vld"}, 8'(bus.out_valid), 8'(v));
    endtask
`else
    task automatic comb(input string tag, input int a, input int b, input logic v);
        drive(a, b, v);
        #1;
        check({tag, "_prod"}, bus.prod, model_prod(a, b));
        check({tag, "_vld"}, 8'(bus.out_valid), 8'(v));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(9, 7, 1'b1);

`ifdef WALLACE_PIPE_EN
        // Held in reset: outputs must stay zero across clock edges
        #1;
        check("rst_prod", bus.prod, 8'd0);
        check("rst_vld", 8'(bus.out_valid), 8'd0);
        @(posedge clk);
        #1;
        check("rst_hold_prod", bus.prod, 8'd0);
        check("rst_hold_vld", 8'(bus.out_valid), 8'd0);
        @(negedge clk);
        reset = 1'b0;

        step("s0", 3, 5, 1'b1);
        step("s1", 7, 9, 1'b1);
        step("s2", 15, 15, 1'b1);

        // Reset between edges clears the held 225 at once
        #2;
        reset = 1'b1;
        #1;
        check("midrst_prod", bus.prod, 8'd0);
        check("midrst_vld", 8'(bus.out_valid), 8'd0);
        @(posedge clk);
        #1;
        check("midrst_hold", bus.prod, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        step("post", 2, 4, 1'b1);

        step("corner_0x9", 0, 9, 1'b0);
        step("corner_1x13", 1, 13, 1'b1);
        step("corner_8x8", 8, 8, 1'b1);
        step("comm_11x6", 11, 6, 1'b1);
        step("comm_6x11", 6, 11, 1'b0);

        for (int n = 0; n < 64; n++) begin
            step("rand", int'($urandom_range(15)), int'($urandom_range(15)),
                 1'($urandom_range(1)));
        end
`else
        // Reset and clk must not disturb the combinational result
        #1;
        check("rst_ignored_prod", bus.prod, model_prod(9, 7));
        check("rst_ignored_vld", 8'(bus.out_valid), 8'd1);
        @(posedge clk);
        #1;
        check("clk_ignored_prod", bus.prod, model_prod(9, 7));
        reset = 1'b0;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(a, b, 1'(b & 1));
                #1;
                check($sformatf("sweep_%0dx%0d", a, b), bus.prod, model_prod(a, b));
            end
        end

        comb("corner_15x15", 15, 15, 1'b1);
        check("corner_225_hex", bus.prod, 8'hE1);
        comb("corner_0x9", 0, 9, 1'b0);
        comb("corner_1x13", 1, 13, 1'b1);
        comb("corner_8x8", 8, 8, 1'b0);
        comb("comm_11x6", 11, 6, 1'b1);
        check("comm_11x6_66", bus.prod, 8'd66);
        comb("comm_6x11", 6, 11, 1'b1);
        check("comm_6x11_66", bus.prod, 8'd66);

        for (int n = 0; n < 64; n++) begin
            comb("rand", int'($urandom_range(15)), int'($urandom_range(15)),
                 1'($urandom_range(1)));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/four_bit_wallace.md
FOUR_BIT_WALLACE -- requirements
Module: four_bit_wallace

Interface
REQ-001 Parameters: none; all widths SHALL be fixed (4-bit operands, 8-bit product).
REQ-002 clk  input  1  single system clock, rising-edge active; used only when WALLACE_PIPE_EN is defined.
REQ-003 reset  input  1  asynchronous, active-high reset; used only when WALLACE_PIPE_EN is defined.
REQ-004 A  input  4  unsigned multiplicand.
REQ-005 B  input  4  unsigned multiplier.
REQ-006 in_valid  input  1  qualifies A/B for the current cycle.
REQ-007 prod  output  8  unsigned product A*B.
REQ-008 out_valid  output  1  qualifies prod.

Function
REQ-009 prod SHALL equal the exact unsigned product A*B for all 256 operand pairs; range 0..225; no truncation or overflow is possible in 8 bits.
REQ-010 Partial products SHALL be pp[i][j] = A[j] AND B[i] for i,j in 0..3, weight 2^(i+j), giving 16 bits.
REQ-011 Reduction SHALL be a Wallace tree: per stage, each column's bits are grouped in threes into full adders and leftover pairs into half adders; sum bits stay in the column and carries move to column+1.
REQ-012 Stages SHALL repeat until every column holds at most two bits; a final carry-propagate (ripple) adder SHALL form prod[7:0].
REQ-013 The datapath SHALL be built only from instantiated half-adder and full-adder cells plus AND gates; the behavioural multiply operator SHALL NOT be used in synthesizable logic.
REQ-014 prod[0] SHALL equal pp[0][0] directly; the carry out of column 7 SHALL be provably zero and discarded.
REQ-015 in_valid SHALL NOT gate the arithmetic; prod always reflects the operands on the path; out_valid only tracks in_valid.
REQ-016 No X SHALL propagate to prod when A and B are known, regardless of in_valid.

Reset
REQ-017 With WALLACE_PIPE_EN defined, reset high SHALL immediately force prod=8'h00 and out_valid=0, independent of clk.
REQ-018 While reset is high the registers SHALL hold zero; the first capture SHALL occur on the first rising clk edge after reset deasserts.
REQ-019 Reset asserted mid-operation SHALL discard the in-flight result; no stale product SHALL appear after release.
REQ-020 Without WALLACE_PIPE_EN, reset and clk SHALL have no effect; outputs are purely combinational.

Configuration
REQ-021 Macro WALLACE_PIPE_EN SHALL select output registering.
REQ-022 Undefined (default): prod and out_valid SHALL be combinational functions of A, B and in_valid, settling within one evaluation delta after any input change.
REQ-023 Defined: prod and out_valid SHALL be registered on rising clk; latency exactly 1 cycle; throughput one operation per cycle; out_valid SHALL be in_valid delayed one cycle.
REQ-024 Port list SHALL be identical in both configurations.

Verification
REQ-025 Exhaustive sweep, macro undefined: A=0..15 x B=0..15, check after 1 time unit -> prod==A*B for all 256; score 256.
REQ-026 Corners: A=15,B=15 -> prod=225 (8'hE1); A=0,B=9 -> 0; A=1,B=13 -> 13; A=8,B=8 -> 64.
REQ-027 Commutativity: A=11,B=6 and A=6,B=11 -> prod=66 in both cases.
REQ-028 Pipelined (macro defined): back-to-back in_valid with (3,5),(7,9),(15,15) -> out_valid high on the following cycles with prod 15, 63, 225 in order.
REQ-029 Reset mid-stream (macro defined): assert reset between clock edges while prod=225 -> prod=0 and out_valid=0 immediately; after release, the next input (2,4) -> prod=8 one cycle later.
